// File: rtl/apb_bridge_pkg.sv
// Shared types and defaults for the request-to-APB bridge.
// The response struct reserves room for the widest supported data bus (64 bits).
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
  localparam int unsigned RSP_DATA_MAX       = 64;

  typedef struct packed {
    logic [RSP_DATA_MAX-1:0] rdata;
    logic                    err;
  } rsp_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog counter, used only when APB_BRIDGE_TIMEOUT_EN is defined.
// expired_o flags the enabled cycle whose increment would reach the limit.
module apb_timeout_cnt #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic [CNT_WIDTH-1:0] limit_i,
  output logic                 expired_o
);

  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign expired_o = enable_i &&
                     (({1'b0, cnt_q} + (CNT_WIDTH + 1)'(1)) >= {1'b0, limit_i});

endmodule

// File: rtl/apb_req_bridge.sv
// Valid/ready request to APB master bridge (IDLE -> SETUP -> ACCESS -> RESP).
// Define APB_BRIDGE_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT_CYCLES cycles.
module apb_req_bridge
  import apb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  pwrite_q;
  rsp_t                  rsp_q;
  logic                  timeout;

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  // SETUP always precedes ACCESS, so clearing there restarts the count on entry.
  apb_timeout_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (state_q == ST_SETUP),
    .enable_i  ((state_q == ST_ACCESS) && !pready_i),
    .limit_i   (CNT_WIDTH'(TIMEOUT_CYCLES)),
    .expired_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // NOTE: the datapath registers are reset along with the state because the
  // APB address/data outputs must read 0 after reset; all updates use <=.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rsp_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            paddr_q  <= req_addr_i;
            pwdata_q <= req_wdata_i;
            pwrite_q <= req_write_i;
            state_q  <= ST_SETUP;
          end
        end
        ST_SETUP: state_q <= ST_ACCESS;
        ST_ACCESS: begin
          // A slave completion in the limit cycle takes priority over the timeout.
          if (pready_i) begin
            rsp_q.err   <= pslverr_i;
            rsp_q.rdata <= pwrite_q ? '0 : RSP_DATA_MAX'(prdata_i);
            state_q     <= ST_RESP;
          end else if (timeout) begin
            rsp_q.err   <= 1'b1;
            rsp_q.rdata <= '0;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign psel_o      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable_o   = (state_q == ST_ACCESS);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign rsp_rdata_o = DATA_WIDTH'(rsp_q.rdata);
  assign rsp_err_o   = rsp_q.err;

endmodule

// File: tb/tb_apb_req_bridge.sv
// Scoreboard bench for apb_req_bridge: expected responses are queued at request
// time and compared when the bridge presents them; a small APB slave model answers.
module tb_apb_req_bridge;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] paddr_o, pwdata_o, prdata_i;
  logic        pready_i, pslverr_i;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Slave model configuration, changed only while the bridge is idle.
  int          slv_wait  = 0;
  logic        slv_err   = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  int          acc_n     = 0;

  apb_req_bridge #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .pwrite_o    (pwrite_o),
    .paddr_o     (paddr_o),
    .pwdata_o    (pwdata_o),
    .prdata_i    (prdata_i),
    .pready_i    (pready_i),
    .pslverr_i   (pslverr_i)
  );

  always #5 clk = ~clk;

  // Slave: ready after slv_wait stalled ACCESS cycles; noisy response pins otherwise.
  always @(negedge clk) begin
    if (psel_o && penable_o) begin
      pready_i  = (acc_n == slv_wait);
      pslverr_i = pready_i ? slv_err : 1'b1;
      prdata_i  = pready_i ? slv_rdata : 32'hBAD0_BAD0;
      acc_n++;
    end else begin
      acc_n     = 0;
      pready_i  = 1'b1;
      pslverr_i = 1'b1;
      prdata_i  = 32'hFACE_F00D;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic take_rsp(input int hold);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    rsp_ready_i = (hold == 0);
    check("rsp_valid", 64'(rsp_valid_o), 64'd1);
    check("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
    check("rsp_err", 64'(rsp_err_o), 64'(e.err));
    check("rsp_psel", 64'(psel_o), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rsp", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, {1'b1, e.err, e.rdata});
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check("back_idle", {rsp_valid_o, req_ready_o}, 64'b01);
  endtask

  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input int exp_acc, input int hold, input string name);
    int acc;
    int guard;
    guard = 0;
    while (!req_ready_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_ready"}, 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    rsp_ready_i = 1'b1;  // must be ignored outside RESP
    sb.push_back('{rdata: exp_rd, err: exp_err});
    @(negedge clk);
    req_valid_i = 1'b0;
    req_write_i = ~wr;
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    check({name, "_setup"}, {psel_o, penable_o, req_ready_o}, 64'b100);
    check({name, "_setup_addr"}, 64'(paddr_o), 64'(addr));
    @(negedge clk);
    acc = 0;
    while (psel_o && acc < 64) begin
      check({name, "_access"}, {psel_o, penable_o}, 64'b11);
      check({name, "_paddr"}, 64'(paddr_o), 64'(addr));
      check({name, "_pwdata"}, {pwrite_o, pwdata_o}, {wr, wdata});
      acc++;
      @(negedge clk);
    end
    check({name, "_acc_cycles"}, 64'(acc), 64'(exp_acc));
    take_rsp(hold);
  endtask

  initial begin
    logic        seen_valid;
    logic        b_wr;
    logic [31:0] b_addr, b_wdata;
    int          last_hs, guard;
    logic        advance;
    exp_t        e;

    rst_i = 1'b1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i  = 32'h0;
    req_wdata_i = 32'h0;
    rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o, req_ready_o}, 64'b000001);
    check("rst_paddr", 64'(paddr_o), 64'd0);
    check("rst_pwdata", 64'(pwdata_o), 64'd0);
    check("rst_rdata", 64'(rsp_rdata_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Zero-wait write: one ACCESS cycle, write response carries rdata 0.
    slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'h1111_2222;
    txn(1'b1, 32'h0, 32'h41, 32'h0, 1'b0, 1, 0, "wr41");

    // Read with three wait states.
    slv_wait = 3; slv_err = 1'b0; slv_rdata = 32'h60;
    txn(1'b0, 32'h14, 32'h0, 32'h60, 1'b0, 4, 0, "rd14");

    // Slave error with data; requester stalls the response for 5 cycles.
    slv_wait = 1; slv_err = 1'b1; slv_rdata = 32'hDEAD;
    txn(1'b0, 32'h28, 32'h5, 32'hDEAD, 1'b1, 2, 5, "rderr");

    // Error on a write still reports rdata 0.
    slv_wait = 0; slv_err = 1'b1;
    txn(1'b1, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 32'h0, 1'b1, 1, 1, "wrerr");

`ifdef APB_BRIDGE_TIMEOUT_EN
    slv_wait = 100; slv_err = 1'b0; slv_rdata = 32'h77;
    txn(1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 8, 0, "tmo");
    slv_wait = 7;
    txn(1'b0, 32'h24, 32'h0, 32'h77, 1'b0, 8, 0, "tmo_win");
`endif

    // Reset in the middle of ACCESS aborts without a response.
    slv_wait = 20; slv_err = 1'b0; slv_rdata = 32'h99;
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h30; req_wdata_i = 32'h7;
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_access", {psel_o, penable_o}, 64'b11);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("abort_ctrl", {psel_o, penable_o, rsp_valid_o, req_ready_o}, 64'b0001);
    check("abort_paddr", 64'(paddr_o), 64'd0);
    seen_valid = 1'b0;
    rsp_ready_i = 1'b1;
    repeat (8) begin
      @(negedge clk);
      seen_valid |= rsp_valid_o | psel_o;
    end
    rsp_ready_i = 1'b0;
    check("abort_no_rsp", 64'(seen_valid), 64'd0);
    slv_wait = 2;
    txn(1'b0, 32'h34, 32'h0, 32'h99, 1'b0, 3, 0, "after_rst");

    // Back-to-back requests with req_valid_i held high and rsp_ready_i high.
    slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'h0BB0;
    b_wr = 1'b1; b_addr = 32'h100; b_wdata = 32'h500;
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1;
    last_hs = -1;
    advance = 1'b0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (advance) begin
        b_wr = ~b_wr; b_addr += 32'h4; b_wdata += 32'h1;
        advance = 1'b0;
      end
      req_write_i = b_wr; req_addr_i = b_addr; req_wdata_i = b_wdata;
      check("b2b_one_phase",
            64'($countones({req_ready_o, psel_o && !penable_o, psel_o && penable_o, rsp_valid_o})),
            64'd1);
      if (rsp_valid_o) begin
        if (sb.size() == 0) check("b2b_sb_underflow", 64'd0, 64'd1);
        else begin
          e = sb.pop_front();
          check("b2b_rsp", {rsp_err_o, rsp_rdata_o}, {e.err, e.rdata});
        end
      end
      if (req_ready_o) begin
        sb.push_back('{rdata: (b_wr ? 32'h0 : slv_rdata), err: 1'b0});
        if (last_hs >= 0) check("b2b_gap", 64'(cyc - last_hs), 64'd4);
        last_hs = cyc;
        advance = 1'b1;
      end
      @(negedge clk);
    end
    req_valid_i = 1'b0;
    guard = 0;
    while (sb.size() != 0 && guard < 10) begin
      if (rsp_valid_o) begin
        e = sb.pop_front();
        check("b2b_drain", {rsp_err_o, rsp_rdata_o}, {e.err, e.rdata});
      end
      @(negedge clk);
      guard++;
    end
    rsp_ready_i = 1'b0;
    check("b2b_sb_empty", 64'(sb.size()), 64'd0);
    check("b2b_end_idle", 64'(req_ready_o), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_req_bridge.md
APB_REQ_BRIDGE -- requirements
Module: apb_req_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the request and APB address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the write and read data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, SHALL set the ACCESS-phase cycle limit when the timeout is compiled in.
REQ-004 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset; synchronous, active-high.
REQ-006 req_valid_i  in  1  request offered.
REQ-007 req_ready_o  out  1  bridge able to accept a request.
REQ-008 req_write_i  in  1  1 = write, 0 = read.
REQ-009 req_addr_i  in  ADDR_WIDTH  byte address.
REQ-010 req_wdata_i  in  DATA_WIDTH  write data.
REQ-011 rsp_valid_o  out  1  response available.
REQ-012 rsp_ready_i  in  1  response consumed.
REQ-013 rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes.
REQ-014 rsp_err_o  out  1  slave error or timeout.
REQ-015 psel_o, penable_o, pwrite_o  out  1 each  APB master controls.
REQ-016 paddr_o  out  ADDR_WIDTH; pwdata_o  out  DATA_WIDTH  APB master address and write data.
REQ-017 prdata_i  in  DATA_WIDTH; pready_i  in  1; pslverr_i  in  1  APB slave response.

Function
REQ-018 FSM states SHALL be IDLE, SETUP, ACCESS and RESP; all outputs SHALL be registered or decoded from state only.
REQ-019 req_ready_o SHALL equal (state == IDLE); on a valid/ready handshake, write, addr and wdata SHALL be captured and state SHALL go to SETUP.
REQ-020 SETUP SHALL last exactly one cycle with psel_o=1 and penable_o=0, then go to ACCESS.
REQ-021 ACCESS SHALL drive psel_o=1 and penable_o=1 until a cycle with pready_i=1.
REQ-022 In that cycle, pslverr_i SHALL be captured into rsp_err_o; prdata_i SHALL be captured into rsp_rdata_o for reads, and rsp_rdata_o SHALL be 0 for writes; state SHALL go to RESP.
REQ-023 paddr_o, pwdata_o and pwrite_o SHALL stay constant from SETUP through the final ACCESS cycle, and SHALL hold their last values while psel_o=0.
REQ-024 RESP SHALL assert rsp_valid_o and hold rsp_rdata_o and rsp_err_o stable until rsp_ready_i=1, then return to IDLE.
REQ-025 Minimum latency: handshake at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid_o at N+3 when pready_i=1 at N+2; maximum throughput is one transaction per 4 cycles.
REQ-026 rsp_ready_i outside RESP, and pready_i or pslverr_i outside ACCESS, SHALL be ignored.
REQ-027 req_valid_i while not IDLE SHALL be ignored; the request SHALL not be lost, because it is held by the requester.

Reset
REQ-028 With rst_i=1 at a clock edge, state SHALL be IDLE and all outputs, including paddr_o and pwdata_o, SHALL be 0 in the following cycle.
REQ-029 Reset asserted mid-transaction SHALL abort it: psel_o=0 in the next cycle, and no response is produced.

Configuration
REQ-030 Macro APB_BRIDGE_TIMEOUT_EN defined: a counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without pready_i.
REQ-031 When the counter reaches TIMEOUT_CYCLES, the bridge SHALL go to RESP with rsp_err_o=1 and rsp_rdata_o=0, and psel_o=0 in the next cycle.
REQ-032 pready_i=1 in the cycle the limit is reached SHALL win, giving a normal completion.
REQ-033 Macro undefined: no counter logic SHALL exist, and ACCESS SHALL wait indefinitely for pready_i.

Structure
REQ-034 Package apb_bridge_pkg SHALL hold the state enum, the response struct (rdata, err) and the default TIMEOUT_CYCLES constant.
REQ-035 Sub-module apb_timeout_cnt (clear, enable, limit, expired) SHALL be instantiated only under APB_BRIDGE_TIMEOUT_EN.

Verification
REQ-036 Write 0x41 to address 0x0, pready_i tied 1 -> psel high for cycles N+1 and N+2, penable high at N+2, pwdata_o=0x41, rsp_valid_o at N+3, rsp_err_o=0, rsp_rdata_o=0.
REQ-037 Read address 0x14, slave returns 0x60 after 3 wait cycles -> penable high 4 cycles, paddr_o stable at 0x14, rsp_rdata_o=0x60.
REQ-038 Read with pslverr_i=1 and prdata_i=0xDEAD -> rsp_err_o=1, rsp_rdata_o=0xDEAD; rsp_ready_i held low 5 cycles -> response stable for those 5 cycles.
REQ-039 TIMEOUT_EN defined, TIMEOUT_CYCLES=8, pready_i=0 -> rsp_err_o=1 after 8 ACCESS cycles; pready_i=1 on the 8th cycle instead -> rsp_err_o=0.
REQ-040 rst_i pulsed during ACCESS -> psel_o=0 next cycle, no rsp_valid_o, and a new request is accepted normally afterwards.
REQ-041 Back-to-back requests with req_valid_i held high -> each accepted only in IDLE, one transaction per 4 cycles, and no APB phase overlap.
